deser_feed_arbiter: RTL and testbench
=====================================

# deser_feed_arbiter

Controller that shares the serial write port of the deserializer between two byte requesters. It arbitrates round-robin, then bit-serialises the granted byte LSB-first onto `data_out`/`write_out` with programmable pulse timing. A transfer starts only when the deserializer reports ready (`status_in`) and the downstream queue has room (`queue_len_in`). It sits in `top` between the byte sources and the deserializer's `data_in`/`write_in` pins.

## Interface
- `PULSE_W`, 10: cycles `write_out` is high per bit, and also cycles low between bits; must be ≥1.
- `LEAD_CYC`, 10: cycles between grant and first `write_out` rise, with bit 0 already on `data_out`; must be ≥1.
- `GAP_CYC`, 10: idle cycles after the last bit's low phase before re-arbitration; must be ≥1.
- `Q_LIMIT`, 8: a transfer starts only if `queue_len_in < Q_LIMIT`.
- `clock` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req0_in`, `req1_in` in 1 each: request, held high until the matching ack.
- `data0_in`, `data1_in` in 8 each: byte for each requester, sampled in the grant cycle.
- `ack0_out`, `ack1_out` out 1 each: one-cycle grant pulse.
- `status_in` in 1: deserializer ready.
- `queue_len_in` in 4: current queue occupancy.
- `data_out` out 1: serial bit to the deserializer `data_in`.
- `write_out` out 1: bit strobe to the deserializer `write_in`.
- `busy_out` out 1: high from the grant edge until return to IDLE.
- `sent_count_out` out 8: completed bytes, wraps 255→0.

## Operation
- **FSM states:** IDLE, LEAD, HIGH, LOW, GAP.
- **Reset values** (every output 0, internal state cleared): `ack*_out`, `data_out`, `write_out`, `busy_out` = 0; `sent_count_out` = 0; state IDLE; bit index 0; `last_grant` = 1, so requester 0 wins the first tie.
- **IDLE, start condition:** a grant is issued when `status_in`=1, `queue_len_in` < `Q_LIMIT`, and any request is high. At the next edge:
  - the winner's ack is 1 for exactly one cycle;
  - the winner's byte is latched into the shift register;
  - `data_out` = bit 0, `busy_out` = 1, state = LEAD.
- **Arbitration:**
  - If only one request is high, it wins.
  - If both are high, the requester ≠ `last_grant` wins.
  - `last_grant` updates on every grant.
- **LEAD:** lasts `LEAD_CYC` cycles with `write_out`=0, then goes to HIGH.
- **HIGH:** `write_out`=1 for `PULSE_W` cycles; `data_out` is held stable. Then goes to LOW.
- **LOW:** `write_out`=0 for `PULSE_W` cycles.
  - On the first LOW cycle, if the bit index is <7, `data_out` changes to the next bit. This gives ≥`PULSE_W` cycles of setup before the next rise, and hold across the whole high phase.
  - At the end of LOW: index <7 → HIGH with index+1; index =7 → GAP.
- **GAP:** `write_out`=0, `data_out`=0 for `GAP_CYC` cycles. `sent_count_out` increments on GAP entry. At the end of GAP: `busy_out`=0, state = IDLE.
- **Condition checks:** `status_in` and `queue_len_in` are checked only in IDLE. Changes mid-byte are ignored, and the byte always completes.
- **Request/data rules:**
  - A request dropped before grant is never acked.
  - Requests are never acked while busy.
  - `data*_in` is don't-care outside the grant cycle.
- **Reset mid-transfer:** every output returns to its reset value at the next edge and the partial byte is abandoned. Resynchronising the deserializer is the responsibility of its own reset, which is shared with this block's.

## Timing
- Grant decision in IDLE cycle T → `ack`, `busy_out`, `data_out`=bit0 at T+1.
- First `write_out` rise at T+1+`LEAD_CYC`.
- Bit k rise at T+1+`LEAD_CYC`+2k·`PULSE_W`.
- `busy_out` high for `LEAD_CYC`+16·`PULSE_W`+`GAP_CYC` cycles; 180 with defaults.
- Earliest next ack: the cycle after `busy_out` falls plus one decision cycle.
- Exactly 8 `write_out` pulses per grant, each exactly `PULSE_W` cycles; no glitches.

## Test plan
- **Single byte:** req0 with 0x99, `status_in`=1, len=0 → one `ack0_out` pulse; 8 pulses of 10 cycles on `write_out`; `data_out` sampled at each rise = 1,0,0,1,1,0,0,1; `sent_count_out`=1; `busy_out` low 180 cycles after the ack.
- **Contention:** req0=0x01 and req1=0x02 held together for 2 words → grant order 0,1. Then repeat both → order 0,1 again; `ack` never asserts while busy.
- **Ready gating:** requests with `status_in`=0 for 50 cycles → no ack. Raise `status_in` → ack 1 cycle after the rise is sampled.
- **Queue full:** `queue_len_in`=8 → no grant. Drop to 7 → grant next cycle. Set len to 8 mid-byte → byte still completes with 8 pulses.
- **Reset mid-byte:** assert `reset` during the bit-3 HIGH phase → next edge `write_out`=0, `busy_out`=0, `sent_count_out`=0. After release with req1 held → `ack1_out` granted and a full byte sent.
- **Wrap and minimum timing:** `PULSE_W`=`LEAD_CYC`=`GAP_CYC`=1 with 256 back-to-back bytes → `sent_count_out` wraps to 0; each byte takes 18 busy cycles.

Source files
------------

// File: rtl/deser_feed_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : deser_feed_arbiter_if
//  Purpose  : Handshake and serial-link bundle between the two byte sources,
//             the feed arbiter and the deserializer write port.
//  Revision : 1.0  initial release
// ============================================================================
interface deser_feed_arbiter_if;
  logic       req0_in;
  logic       req1_in;
  logic [7:0] data0_in;
  logic [7:0] data1_in;
  logic       ack0_out;
  logic       ack1_out;
  logic       status_in;
  logic [3:0] queue_len_in;
  logic       data_out;
  logic       write_out;
  logic       busy_out;
  logic [7:0] sent_count_out;

  // Arbiter side
  modport slave (
    input  req0_in, req1_in, data0_in, data1_in, status_in, queue_len_in,
    output ack0_out, ack1_out, data_out, write_out, busy_out, sent_count_out
  );

  // Requester / environment side
  modport master (
    output req0_in, req1_in, data0_in, data1_in, status_in, queue_len_in,
    input  ack0_out, ack1_out, data_out, write_out, busy_out, sent_count_out
  );
endinterface
`default_nettype wire

// File: rtl/deser_feed_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : deser_feed_arbiter
//  Purpose  : Round-robin arbiter between two byte requesters that
//             bit-serialises the granted byte LSB-first onto the
//             deserializer data/write pins with programmable pulse timing.
//  Revision : 1.0  initial release
// ============================================================================
module deser_feed_arbiter #(
  parameter int PULSE_W  = 10,
  parameter int LEAD_CYC = 10,
  parameter int GAP_CYC  = 10,
  parameter int Q_LIMIT  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  deser_feed_arbiter_if.slave   bus
);

  // Phase counter must hold the largest reload value (max - 1)
  localparam int c_max_a  = (PULSE_W > LEAD_CYC) ? PULSE_W : LEAD_CYC;
  localparam int c_max    = (c_max_a > GAP_CYC) ? c_max_a : GAP_CYC;
  localparam int c_cnt_w  = (c_max > 1) ? $clog2(c_max) : 1;

  localparam logic [c_cnt_w-1:0] c_lead_load  = c_cnt_w'(LEAD_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_pulse_load = c_cnt_w'(PULSE_W - 1);
  localparam logic [c_cnt_w-1:0] c_gap_load   = c_cnt_w'(GAP_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

  // The queue occupancy is 4 bits, so any limit above 15 means "always room"
  localparam logic [4:0] c_q_limit = (Q_LIMIT > 16) ? 5'd16 : 5'(Q_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEAD = 3'd1,
    S_HIGH = 3'd2,
    S_LOW  = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt,   w_cnt_nxt;
  logic [2:0]           r_idx,   w_idx_nxt;
  logic [7:0]           r_shift, w_shift_nxt;
  logic                 r_data,  w_data_nxt;
  logic                 r_ack0,  w_ack0_nxt;
  logic                 r_ack1,  w_ack1_nxt;
  logic                 r_last,  w_last_nxt;
  logic [7:0]           r_sent,  w_sent_nxt;

  logic                 w_start;
  logic                 w_grant0;
  logic                 w_cnt_done;

  // Requester 0 wins when alone or when requester 1 was granted last
  assign w_grant0   = bus.req0_in && (!bus.req1_in || r_last);
  assign w_start    = bus.status_in && ({1'b0, bus.queue_len_in} < c_q_limit) &&
                      (bus.req0_in || bus.req1_in);
  assign w_cnt_done = (r_cnt == '0);

  // State register and datapath registers; reset abandons any partial byte
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'd0;
      r_data  <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_last  <= 1'b1;
      r_sent  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_ack0  <= w_ack0_nxt;
      r_ack1  <= w_ack1_nxt;
      r_last  <= w_last_nxt;
      r_sent  <= w_sent_nxt;
    end
  end

  // Next-state and datapath updates; each phase reloads the counter on exit
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;
    w_last_nxt  = r_last;
    w_sent_nxt  = r_sent;

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_LEAD;
          w_cnt_nxt   = c_lead_load;
          w_idx_nxt   = 3'd0;
          w_ack0_nxt  = w_grant0;
          w_ack1_nxt  = !w_grant0;
          w_last_nxt  = !w_grant0;
          w_shift_nxt = w_grant0 ? bus.data0_in : bus.data1_in;
          w_data_nxt  = w_grant0 ? bus.data0_in[0] : bus.data1_in[0];
        end
      end

      S_LEAD: begin
        if (w_cnt_done) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = c_pulse_load;
        end else begin
          w_cnt_nxt   = r_cnt - c_cnt_one;
        end
      end

      S_HIGH: begin
        if (w_cnt_done) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = c_pulse_load;
          // Present the next bit right after the fall for maximum setup
          if (r_idx != 3'd7) begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_data_nxt  = r_shift[1];
          end
        end else begin
          w_cnt_nxt   = r_cnt - c_cnt_one;
        end
      end

      S_LOW: begin
        if (w_cnt_done) begin
          if (r_idx != 3'd7) begin
            w_state_nxt = S_HIGH;
            w_cnt_nxt   = c_pulse_load;
            w_idx_nxt   = r_idx + 3'd1;
          end else begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = c_gap_load;
            w_data_nxt  = 1'b0;
            w_sent_nxt  = r_sent + 8'd1;
          end
        end else begin
          w_cnt_nxt   = r_cnt - c_cnt_one;
        end
      end

      S_GAP: begin
        if (w_cnt_done) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt   = r_cnt - c_cnt_one;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Strobe and busy are pure decodes of the state register, so glitch-free
  assign bus.write_out      = (r_state == S_HIGH);
  assign bus.busy_out       = (r_state != S_IDLE);
  assign bus.data_out       = r_data;
  assign bus.ack0_out       = r_ack0;
  assign bus.ack1_out       = r_ack1;
  assign bus.sent_count_out = r_sent;

endmodule
`default_nettype wire

// File: tb/tb_deser_feed_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_deser_feed_arbiter
//  Purpose  : Directed self-checking bench for deser_feed_arbiter, default
//             timing instance plus a minimum-timing instance for wrap-around.
//  Revision : 1.0  initial release
// ============================================================================
module tb_deser_feed_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;

  deser_feed_arbiter_if bus ();
  deser_feed_arbiter_if mb  ();

  deser_feed_arbiter #(.PULSE_W(10), .LEAD_CYC(10), .GAP_CYC(10), .Q_LIMIT(8)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  deser_feed_arbiter #(.PULSE_W(1), .LEAD_CYC(1), .GAP_CYC(1), .Q_LIMIT(8)) u_min (
    .clock (clock),
    .reset (reset),
    .bus   (mb)
  );

  always #5 clock = ~clock;

  // Advance one cycle and settle just after the active edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Ticks until either ack is seen; returns ticks taken, or -1 on timeout
  task automatic wait_ack(output int waited);
    waited = -1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (bus.ack0_out === 1'b1 || bus.ack1_out === 1'b1) begin
        waited = i;
        break;
      end
    end
  endtask

  // Observes one byte from the ack cycle until busy drops
  task automatic run_byte(output int pulses, output logic [7:0] bits, output int busy_cyc,
                          output int first_rise, output int bad_shape, output int stray_ack);
    int   run;
    logic prev_w;
    logic held;
    pulses = 0; bits = 8'h00; busy_cyc = 0; first_rise = -1;
    bad_shape = 0; stray_ack = 0; run = 0; prev_w = 1'b0; held = 1'b0;
    while (bus.busy_out === 1'b1 && busy_cyc < 1000) begin
      if (bus.write_out === 1'b1) begin
        if (!prev_w) begin
          if (pulses < 8) bits[pulses] = bus.data_out;
          if (first_rise < 0) first_rise = busy_cyc;
          held = bus.data_out;
          pulses++;
        end else if (bus.data_out !== held) begin
          bad_shape++;
        end
        run++;
      end else begin
        if (prev_w && run != 10) bad_shape++;
        run = 0;
      end
      if (busy_cyc > 0 && (bus.ack0_out === 1'b1 || bus.ack1_out === 1'b1)) stray_ack++;
      prev_w = bus.write_out;
      busy_cyc++;
      tick();
    end
  endtask

  initial begin
    int w, pulses, busy_cyc, first_rise, bad_shape, stray, rises, bytes, run, bad, sent255, cyc;
    logic [7:0] bits;
    logic prevw;

    bus.req0_in = 0; bus.req1_in = 0; bus.data0_in = 0; bus.data1_in = 0;
    bus.status_in = 0; bus.queue_len_in = 0;
    mb.req0_in = 0; mb.req1_in = 0; mb.data0_in = 0; mb.data1_in = 0;
    mb.status_in = 0; mb.queue_len_in = 0;

    // ---- reset state ----
    reset = 1;
    repeat (3) tick();
    check("rst_outputs", {bus.ack0_out, bus.ack1_out, bus.data_out, bus.write_out, bus.busy_out}, 5'b0);
    check("rst_sent", bus.sent_count_out, 8'd0);
    reset = 0;
    tick();

    // ---- single byte 0x99 ----
    bus.status_in = 1; bus.queue_len_in = 0; bus.data0_in = 8'h99; bus.req0_in = 1;
    wait_ack(w);
    check("single_ack_latency", w, 1);
    check("single_ack_sel", {bus.ack0_out, bus.ack1_out}, 2'b10);
    check("single_bit0_busy", {bus.data_out, bus.busy_out, bus.write_out}, 3'b110);
    bus.req0_in = 0;
    run_byte(pulses, bits, busy_cyc, first_rise, bad_shape, stray);
    check("single_pulses", pulses, 8);
    check("single_bits", bits, 8'h99);
    check("single_busy_len", busy_cyc, 180);
    check("single_first_rise", first_rise, 10);
    check("single_shape", bad_shape, 0);
    check("single_sent", bus.sent_count_out, 8'd1);
    check("single_idle_pins", {bus.data_out, bus.write_out}, 2'b00);

    // ---- contention, fresh arbitration history ----
    reset = 1; tick(); reset = 0;
    for (int rep = 0; rep < 2; rep++) begin
      bus.data0_in = 8'h01; bus.data1_in = 8'h02; bus.req0_in = 1; bus.req1_in = 1;
      wait_ack(w);
      check("cont_first_ack", {bus.ack0_out, bus.ack1_out}, 2'b10);
      bus.req0_in = 0;
      run_byte(pulses, bits, busy_cyc, first_rise, bad_shape, stray);
      check("cont_bits0", bits, 8'h01);
      check("cont_stray_ack0", stray, 0);
      wait_ack(w);
      check("cont_next_latency", w, 1);
      check("cont_second_ack", {bus.ack0_out, bus.ack1_out}, 2'b01);
      bus.req1_in = 0;
      run_byte(pulses, bits, busy_cyc, first_rise, bad_shape, stray);
      check("cont_bits1", bits, 8'h02);
      check("cont_stray_ack1", stray, 0);
    end
    check("cont_sent", bus.sent_count_out, 8'd4);

    // ---- ready gating ----
    bus.status_in = 0; bus.data0_in = 8'h5A; bus.req0_in = 1;
    w = 0;
    repeat (50) begin
      tick();
      if (bus.ack0_out === 1'b1 || bus.ack1_out === 1'b1 || bus.busy_out === 1'b1) w++;
    end
    check("ready_blocked", w, 0);
    bus.status_in = 1;
    tick();
    check("ready_ack", {bus.ack0_out, bus.ack1_out}, 2'b10);
    bus.req0_in = 0;
    run_byte(pulses, bits, busy_cyc, first_rise, bad_shape, stray);
    check("ready_bits", bits, 8'h5A);

    // ---- queue full ----
    bus.queue_len_in = 4'd8; bus.data1_in = 8'hC3; bus.req1_in = 1;
    w = 0;
    repeat (20) begin
      tick();
      if (bus.ack0_out === 1'b1 || bus.ack1_out === 1'b1 || bus.busy_out === 1'b1) w++;
    end
    check("queue_blocked", w, 0);
    bus.queue_len_in = 4'd7;
    tick();
    check("queue_ack", {bus.ack0_out, bus.ack1_out}, 2'b01);
    bus.req1_in = 0;
    bus.queue_len_in = 4'd8;
    run_byte(pulses, bits, busy_cyc, first_rise, bad_shape, stray);
    check("queue_mid_pulses", pulses, 8);
    check("queue_mid_bits", bits, 8'hC3);
    check("queue_mid_busy", busy_cyc, 180);
    bus.queue_len_in = 4'd0;
    check("pre_reset_sent", bus.sent_count_out, 8'd6);

    // ---- reset during bit-3 high phase ----
    bus.data0_in = 8'hFF; bus.req0_in = 1;
    wait_ack(w);
    check("rmid_ack", {bus.ack0_out, bus.ack1_out}, 2'b10);
    bus.req0_in = 0;
    rises = 0; prevw = 0;
    for (int i = 0; i < 200 && rises < 4; i++) begin
      tick();
      if (bus.write_out === 1'b1 && !prevw) rises++;
      prevw = bus.write_out;
    end
    check("rmid_in_bit3_high", {rises[3:0], bus.write_out}, {4'd4, 1'b1});
    reset = 1;
    bus.data1_in = 8'h3C; bus.req1_in = 1;
    tick();
    check("rmid_cleared", {bus.write_out, bus.busy_out, bus.data_out, bus.ack0_out, bus.ack1_out}, 5'b0);
    check("rmid_sent", bus.sent_count_out, 8'd0);
    reset = 0;
    wait_ack(w);
    check("rmid_after_latency", w, 1);
    check("rmid_after_ack", {bus.ack0_out, bus.ack1_out}, 2'b01);
    bus.req1_in = 0;
    run_byte(pulses, bits, busy_cyc, first_rise, bad_shape, stray);
    check("rmid_after_bits", bits, 8'h3C);
    check("rmid_after_pulses", pulses, 8);
    check("rmid_after_sent", bus.sent_count_out, 8'd1);

    // ---- minimum timing, 256 back-to-back bytes ----
    mb.status_in = 1; mb.queue_len_in = 0; mb.data0_in = 8'hA5; mb.req0_in = 1;
    bytes = 0; run = 0; bad = 0; sent255 = -1; cyc = 0; rises = 0; prevw = 0;
    while (bytes < 256 && cyc < 6000) begin
      tick();
      cyc++;
      if (mb.write_out === 1'b1 && !prevw) rises++;
      prevw = mb.write_out;
      if (mb.busy_out === 1'b1) begin
        run++;
      end else if (run != 0) begin
        if (run != 18) bad++;
        bytes++;
        if (bytes == 255) sent255 = int'(mb.sent_count_out);
        run = 0;
      end
    end
    mb.req0_in = 0;
    check("min_bytes_done", bytes, 256);
    check("min_busy_len", bad, 0);
    check("min_sent_255", sent255, 255);
    check("min_sent_wrap", mb.sent_count_out, 8'd0);
    check("min_pulses", rises, 2048);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
